// File: rtl/pkt_fold_arbiter.sv
// pkt_fold_arbiter
//  Packet-level scheduler in front of the shared fold/overlap-add datapath.
//  Two AXI-Stream requesters compete for the datapath. A grant covers one whole
//  packet. The requester's k/len config is latched at grant and is held on
//  cfg_k/cfg_len until the next grant. The packet length is enforced against
//  cfg_len, a settle gap of GAP_CYC idle cycles follows each packet, and
//  err_len pulses for one cycle on a bad config, a short packet or a long packet.
//
//  Optional feature: define ARB_FIXED_PRIO_EN to select fixed priority.
//  In that mode requester 0 wins every tie. When the macro is undefined, a
//  round-robin pointer decides ties.
//
// Ports
//  clk, rst                 clock (rising edge), asynchronous active-low reset
//  s{0,1}_data/valid/last   requester streams
//  s{0,1}_ready             requester ready
//  s{0,1}_k, s{0,1}_len     requester config, sampled on the grant edge
//  d_data/valid/last/ready  datapath stream
//  cfg_k, cfg_len           config latched for the current packet
//  grant                    one-hot owner; 00 when no requester owns the datapath
//  busy                     the scheduler is not idle
//  err_len                  one-cycle pulse on a length or config error
module pkt_fold_arbiter #(
  parameter int Data_width = 8,
  parameter int MAX_LEN    = 10,
  parameter int GAP_CYC    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Data_width-1:0] s0_data,
  input  logic                  s0_valid,
  input  logic                  s0_last,
  output logic                  s0_ready,
  input  logic [Data_width-1:0] s0_k,
  input  logic [Data_width-1:0] s0_len,
  input  logic [Data_width-1:0] s1_data,
  input  logic                  s1_valid,
  input  logic                  s1_last,
  output logic                  s1_ready,
  input  logic [Data_width-1:0] s1_k,
  input  logic [Data_width-1:0] s1_len,
  output logic [Data_width-1:0] d_data,
  output logic                  d_valid,
  output logic                  d_last,
  input  logic                  d_ready,
  output logic [Data_width-1:0] cfg_k,
  output logic [Data_width-1:0] cfg_len,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  err_len
);

  typedef enum logic [1:0] {IDLE, PASS, DROP, GAP} state_t;

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0]         GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [Data_width-1:0] MAXL     = Data_width'(MAX_LEN);
  localparam logic [Data_width-1:0] ONE      = Data_width'(1);

  // Requesters as packed lane arrays so the selected owner is one index.
  logic [1:0][Data_width-1:0] s_data, s_k, s_len;
  logic [1:0]                 s_valid, s_last, s_ready;

  assign s_data  = {s1_data, s0_data};
  assign s_k     = {s1_k, s0_k};
  assign s_len   = {s1_len, s0_len};
  assign s_valid = {s1_valid, s0_valid};
  assign s_last  = {s1_last, s0_last};
  assign s0_ready = s_ready[0];
  assign s1_ready = s_ready[1];

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [Data_width-1:0] cfg_k_q, cfg_k_d, cfg_len_q, cfg_len_d, cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  err_q, err_d;
`ifndef ARB_FIXED_PRIO_EN
  logic                  rr_q, rr_d;  // requester favoured on the next tie
`endif

  logic sel, win, legal, last_cnt, beat, to_gap;

  assign sel      = grant_q[1];
  assign last_cnt = (cnt_q == cfg_len_q - ONE);
  assign beat     = s_valid[sel] & d_ready;

`ifdef ARB_FIXED_PRIO_EN
  assign win = ~s_valid[0];
`else
  assign win = (&s_valid) ? rr_q : s_valid[1];
`endif

  assign legal = (s_len[win] != '0) && (s_len[win] <= MAXL) && (s_k[win] < s_len[win]);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cfg_k_d   = cfg_k_q;
    cfg_len_d = cfg_len_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    err_d     = 1'b0;
    to_gap    = 1'b0;
    s_ready   = '0;
    d_data    = '0;
    d_valid   = 1'b0;
    d_last    = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: if (|s_valid) begin
        grant_d   = win ? 2'b10 : 2'b01;
        cfg_k_d   = s_k[win];
        cfg_len_d = s_len[win];
        cnt_d     = '0;
        state_d   = legal ? PASS : DROP;
        err_d     = ~legal;
      end
      PASS: begin
        d_data       = s_data[sel];
        d_valid      = s_valid[sel];
        d_last       = s_last[sel] | last_cnt;
        s_ready[sel] = d_ready;
        if (beat) begin
          cnt_d = cnt_q + ONE;
          if (s_last[sel]) begin
            to_gap = 1'b1;
            err_d  = ~last_cnt;  // short packet
          end else if (last_cnt) begin
            // Long packet: the datapath has seen a forced last, so the tail is discarded.
            state_d = DROP;
            err_d   = 1'b1;
          end
        end
      end
      DROP: begin
        s_ready[sel] = 1'b1;
        if (s_valid[sel] & s_last[sel]) to_gap = 1'b1;
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
    if (to_gap) begin
      state_d = GAP;
      gap_d   = '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_d    = ~sel;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      cfg_k_q   <= '0;
      cfg_len_q <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cfg_k_q   <= cfg_k_d;
      cfg_len_q <= cfg_len_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign err_len = err_q;
  assign cfg_k   = cfg_k_q;
  assign cfg_len = cfg_len_q;

endmodule

// File: tb/tb_pkt_fold_arbiter.sv
// tb_pkt_fold_arbiter
//  Directed bench for pkt_fold_arbiter. Each run_pkt call drives one packet of
//  beats 1..n on one requester. On every accepted cycle it checks the datapath
//  side against values derived from the packet's len, k and n. Ties run the two
//  requesters in parallel and check the service order.
module tb_pkt_fold_arbiter;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sd[2], sk[2], slen[2];
  logic [1:0] sv = '0, sl = '0, srdy;
  logic       d_ready = 1'b1;
  logic [7:0] d_data, cfg_k, cfg_len;
  logic       d_valid, d_last, busy, err_len;
  logic [1:0] grant;

  int n_cmp = 0, n_bad = 0, errs = 0;
  int order[$];

  pkt_fold_arbiter #(.Data_width(8), .MAX_LEN(10), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst),
    .s0_data(sd[0]), .s0_valid(sv[0]), .s0_last(sl[0]), .s0_ready(srdy[0]),
    .s0_k(sk[0]), .s0_len(slen[0]),
    .s1_data(sd[1]), .s1_valid(sv[1]), .s1_last(sl[1]), .s1_ready(srdy[1]),
    .s1_k(sk[1]), .s1_len(slen[1]),
    .d_data(d_data), .d_valid(d_valid), .d_last(d_last), .d_ready(d_ready),
    .cfg_k(cfg_k), .cfg_len(cfg_len), .grant(grant), .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_len) errs++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drives packet beats 1..n on requester `who`, with last on beat n.
  task automatic run_pkt(input int who, input int len, input int k, input int n);
    int  i = 1, cyc = 0;
    bit  first = 1;
    bit  legal = (len >= 1) && (len <= 10) && (k < len);
    bit  ev;
    sk[who] = 8'(k); slen[who] = 8'(len);
    forever begin
      @(negedge clk);
      if (i > n) begin sv[who] = 0; sl[who] = 0; break; end
      if (cyc > 200) begin chk("timeout", 1, 0); sv[who] = 0; break; end
      sv[who] = 1; sd[who] = 8'(i); sl[who] = (i == n);
      #1;
      if (srdy[who]) begin
        if (first) begin
          order.push_back(who);
          chk("grant", grant, 32'(1 << who));
          chk("cfg_len", cfg_len, len);
          chk("cfg_k", cfg_k, k);
          first = 0;
        end
        ev = legal && (i <= len);
        chk("d_valid", d_valid, ev);
        if (ev) begin
          chk("d_data", d_data, i);
          chk("d_last", d_last, (i == n) || (i == len));
        end
        i++;
      end
      cyc++;
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    while (busy && c < 30) begin @(negedge clk); c++; end
    chk("idle", busy, 0);
  endtask

  task automatic tie(input int first_who);
    order.delete();
    fork
      run_pkt(0, 3, 1, 3);
      run_pkt(1, 3, 2, 3);
    join
    wait_idle();
    chk("tie_first", order.size() > 0 ? order[0] : -1, first_who);
    chk("tie_second", order.size() > 1 ? order[1] : -1, 1 - first_who);
  endtask

  initial begin
    int e0, c;
    sd[0] = 0; sd[1] = 0; sk[0] = 0; sk[1] = 0; slen[0] = 0; slen[1] = 0;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_len", cfg_len, 0);
    chk("rst_cfg_k", cfg_k, 0);
    chk("rst_err", err_len, 0);
    chk("rst_dvalid", d_valid, 0);
    @(negedge clk); rst = 1;

    // Ties from reset: s0, then s1. The repeat tie serves s0 first again.
    tie(0);
    tie(0);

    // A lone s0 packet: len=4, k=2, 4 beats, then exactly GAP busy cycles.
    e0 = errs;
    run_pkt(0, 4, 2, 4);
    for (int g = 0; g < GAP; g++) begin
      chk("gap_busy", busy, 1);
      chk("gap_dvalid", d_valid, 0);
      chk("gap_s0rdy", srdy[0], 0);
      @(negedge clk);
    end
    chk("post_gap_busy", busy, 0);
    chk("post_gap_grant", grant, 0);
    chk("cfg_len_held", cfg_len, 4);
    chk("t1_err", errs - e0, 0);

    // s0 was served last, so in round-robin mode s1 wins this tie.
`ifdef ARB_FIXED_PRIO_EN
    tie(0);
`else
    tie(1);
`endif

    // Short packet on s1.
    e0 = errs;
    run_pkt(1, 5, 1, 3);
    wait_idle();
    chk("short_err", errs - e0, 1);

    // Long packet on s0.
    e0 = errs;
    run_pkt(0, 3, 0, 6);
    wait_idle();
    chk("long_err", errs - e0, 1);

    // Illegal configs are dropped whole.
    e0 = errs; run_pkt(0, 0, 0, 2);  wait_idle(); chk("len0_err", errs - e0, 1);
    e0 = errs; run_pkt(0, 11, 1, 3); wait_idle(); chk("len11_err", errs - e0, 1);
    e0 = errs; run_pkt(1, 4, 4, 2);  wait_idle(); chk("klen_err", errs - e0, 1);

    // An illegal s0 packet is followed by service of s1.
    e0 = errs;
    order.delete();
    fork
      run_pkt(0, 3, 3, 2);
      begin @(negedge clk); run_pkt(1, 2, 1, 2); end
    join
    wait_idle();
    chk("drop_then_s1", order.size() > 1 ? order[1] : -1, 1);
    chk("drop_err", errs - e0, 1);

    // Asynchronous reset during beat 2 of a len=8 packet.
    @(negedge clk);
    sv[0] = 1; sd[0] = 1; sl[0] = 0; sk[0] = 1; slen[0] = 8;
    c = 0;
    #1;
    while (!srdy[0] && c < 20) begin @(negedge clk); #1; c++; end
    chk("rst_pkt_granted", srdy[0], 1);
    @(negedge clk); sd[0] = 2;
    #1; rst = 0; #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cfg_len", cfg_len, 0);
    chk("arst_dvalid", d_valid, 0);
    chk("arst_s0rdy", srdy[0], 0);
    @(negedge clk); sv[0] = 0; rst = 1;
    run_pkt(0, 2, 1, 2);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
